seg_scan: RTL and testbench



---
 rtl/seg_scan.sv | 84 ++++++++
 tb/tb_seg_scan.sv | 132 +++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: eight-digit seven-segment scanner with frame-aligned double buffering
module seg_scan #(
   parameter int                      DIGITS  = 8,
   parameter logic [4*DIGITS-1:0]     RST_VAL = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  scan_clk_i,
   input  logic [4*DIGITS-1:0]   data_i,
   input  logic                  data_we_i,
   input  logic [DIGITS-1:0]     digit_en_i,
   input  logic [DIGITS-1:0]     dp_i,
   output logic [DIGITS-1:0]     led_en_o,
   output logic [7:0]            seg_o,
   output logic                  frame_o
);
   localparam int IW = $clog2(DIGITS);
   localparam logic [15:0][6:0] LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };
   typedef enum logic {IDLE, BLANK} state_t;
   state_t               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 scan_q;
   logic [DIGITS-1:0]    led_q, led_d;
   logic [7:0]           seg_q, seg_d;
   logic                 frame_q, frame_d;
   logic                 pend_q, pend_d;
   logic [4*DIGITS-1:0]  shadow_q, shadow_d, disp_q, disp_d;
   logic                 tick, wrap;
   assign tick = scan_clk_i & ~scan_q;
   assign wrap = (state_q == IDLE) & tick & (idx_q == IW'(DIGITS - 1));
   // A write on the wrap cycle goes straight into the new frame.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      led_d    = led_q;
      seg_d    = seg_q;
      frame_d  = 1'b0;
      shadow_d = data_we_i ? data_i : shadow_q;
      pend_d   = (pend_q | data_we_i) & ~wrap;
      disp_d   = wrap ? (data_we_i ? data_i : (pend_q ? shadow_q : disp_q)) : disp_q;
      if (state_q == IDLE && tick) begin
         state_d = BLANK;
         idx_d   = idx_q + 1'b1;
         led_d   = '1;
         seg_d   = '1;
         frame_d = wrap;
      end else if (state_q == BLANK) begin
         state_d = IDLE;
         if (digit_en_i[idx_q]) begin
            led_d = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
            seg_d = {~dp_i[idx_q], LUT[disp_q[4*idx_q +: 4]]};
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         scan_q   <= 1'b0;
         led_q    <= '1;
         seg_q    <= '1;
         frame_q  <= 1'b0;
         pend_q   <= 1'b0;
         shadow_q <= RST_VAL;
         disp_q   <= RST_VAL;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         scan_q   <= scan_clk_i;
         led_q    <= led_d;
         seg_q    <= seg_d;
         frame_q  <= frame_d;
         pend_q   <= pend_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
      end
   end
   assign led_en_o = led_q;
   assign seg_o    = seg_q;
   assign frame_o  = frame_q;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized scoreboard bench for seg_scan against a per-digit display model
module tb_seg_scan;
   logic        clk = 0, rst = 1, scan = 0, we = 0;
   logic [31:0] data = 0;
   logic [7:0]  en = '1, dp = '0;
   logic [7:0]  led, seg;
   logic        frame;
   always #5 clk = ~clk;
   seg_scan dut (
      .clk_i(clk), .rst_i(rst), .scan_clk_i(scan), .data_i(data), .data_we_i(we),
      .digit_en_i(en), .dp_i(dp), .led_en_o(led), .seg_o(seg), .frame_o(frame)
   );
   int lut [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                    'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};
   int          m_idx;
   bit          m_blank, m_prev, m_pend, m_frame, m_rise;
   logic [31:0] m_disp, m_shadow;
   logic [7:0]  m_led, m_seg;
   logic [16:0] expq [$];
   logic [16:0] mon_exp;
   int compared = 0, mismatched = 0;
   // Reference: a tick starts a dark slot on the next digit, the digit lights one cycle later.
   always @(posedge clk) begin
      if (rst) begin
         m_idx = 0; m_blank = 0; m_prev = 0; m_pend = 0; m_frame = 0;
         m_disp = 0; m_shadow = 0; m_led = '1; m_seg = '1;
      end else begin
         m_rise = scan && !m_prev;
         m_prev = scan;
         m_frame = 0;
         if (we) begin m_shadow = data; m_pend = 1; end
         if (m_blank) begin
            m_blank = 0;
            if (en[m_idx]) begin
               m_led = ~(8'd1 << m_idx);
               m_seg = (dp[m_idx] ? 8'h00 : 8'h80) | 8'(lut[m_disp[4*m_idx +: 4]]);
            end
         end else if (m_rise) begin
            m_idx = (m_idx + 1) % 8;
            m_led = '1; m_seg = '1; m_blank = 1;
            if (m_idx == 0) begin
               m_frame = 1;
               if (m_pend) m_disp = m_shadow;
               m_pend = 0;
            end
         end
      end
      expq.push_back({m_frame, m_led, m_seg});
   end
   always @(posedge clk) begin
      #1;
      compared++;
      if (expq.size() == 0) begin
         mismatched++;
         $display("FAIL scoreboard_empty @%0t: got frame=%b led=%h seg=%h, no expected entry", $time, frame, led, seg);
      end else begin
         mon_exp = expq.pop_front();
         if ({frame, led, seg} !== mon_exp)
            begin
               mismatched++;
               $display("FAIL outputs @%0t: got frame=%b led=%h seg=%h, required frame=%b led=%h seg=%h",
                        $time, frame, led, seg, mon_exp[16], mon_exp[15:8], mon_exp[7:0]);
            end
      end
   end
   int          cnt = 0, per = 4;
   bit          wr_req = 0, force_rise = 0, rnd = 0;
   logic [31:0] wr_data = 0;
   task automatic run(int n);
      repeat (n) begin
         @(negedge clk);
         we = wr_req;
         data = wr_req ? wr_data : $urandom;
         wr_req = 0;
         if (force_rise) begin
            scan = 1; cnt = 0; force_rise = 0;
         end else if (++cnt >= per) begin
            cnt = 0; scan = ~scan;
            if (rnd) per = $urandom_range(1, 5);
         end
      end
   endtask
   task automatic wait_lit(int i, bit need_low);
      int k = 0;
      while (!(m_idx == i && !m_blank && (!need_low || scan == 0)) && k < 200) begin
         run(1);
         k++;
      end
      if (k >= 200) begin
         compared++;
         mismatched++;
         $display("FAIL wait_digit%0d timeout: idx=%0d required %0d", i, m_idx, i);
      end
   endtask
   initial begin
      run(3);
      rst = 0;
      wr_req = 1; wr_data = 32'h76543210; run(1);
      run(150);
      dp = '1;
      wr_req = 1; wr_data = 32'hFEDCBA98; run(1);
      run(150);
      dp = '0; en = 8'hAA;
      wr_req = 1; wr_data = 32'hFFFFFFFF; run(1);
      run(150);
      en = '1;
      wait_lit(3, 0); wr_req = 1; wr_data = 32'h11111111; run(1);
      wait_lit(5, 0); wr_req = 1; wr_data = 32'h22222222; run(1);
      run(150);
      wait_lit(7, 1); force_rise = 1; wr_req = 1; wr_data = 32'h9; run(1);
      run(150);
      wait_lit(5, 0);
      rst = 1; scan = 0; cnt = 0; per = 100000;
      run(1);
      rst = 0;
      run(5);
      per = 4; force_rise = 1; run(40);
      rnd = 1;
      repeat (3000) begin
         wr_req = ($urandom_range(0, 7) == 0);
         wr_data = $urandom;
         if ($urandom_range(0, 15) == 0) en = 8'($urandom);
         if ($urandom_range(0, 15) == 0) dp = 8'($urandom);
         rst = ($urandom_range(0, 399) == 0);
         run(1);
      end
      rst = 0;
      run(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
